pu_or1k_pfpu32_f2i: RTL and testbench
=====================================

Name: pu_or1k_pfpu32_f2i

Overview:
Single-precision float to signed 32-bit integer converter for the pfpu32 unit. It is the reverse-direction counterpart of the integer-to-float front end. The pipeline has two stages, both gated by the shared `adv_i`/`flush_i` pipe controls: stage 1 unpacks and classifies the operand, stage 2 shifts, rounds and saturates. It delivers the integer result and exception flags directly to the pfpu32 output mux.

Parameters:
None.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  flush pipe; clears valid tokens
adv_i  in  1  advance pipe; enables every pipeline register
start_i  in  1  start conversion of opa_i (sampled when adv_i=1)
opa_i  in  32  IEEE-754 single operand
rmode_i  in  2  rounding mode: 00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf
f2i_rdy_o  out  1  result valid
f2i_int_o  out  32  signed two's-complement result
f2i_ine_o  out  1  inexact flag
f2i_inv_o  out  1  invalid flag (NaN, infinity or out of range)

Behaviour:
- Reset (rst_n=0, async): s1 valid, f2i_rdy_o, f2i_int_o, f2i_ine_o and f2i_inv_o all 0. Stage-1 data registers are also cleared to 0.
- Valid chain:
  - Priority rst_n > flush_i > adv_i.
  - flush_i=1: s1 valid and f2i_rdy_o go to 0 regardless of adv_i; data registers are unchanged.
  - adv_i=1: s1 valid <= start_i; f2i_rdy_o <= s1 valid.
  - adv_i=0: everything holds.
- Latency: exactly 2 advancing cycles from start_i to f2i_rdy_o. Back-to-back starts give 1 result per advancing cycle.
- Data registers load only when adv_i=1, independent of start_i and flush_i.
- Stage 1 (registered):
  - sign = opa_i[31], e = opa_i[30:23], m24 = {e!=0, opa_i[22:0]}, rmode.
  - nan = (e==255 && frac!=0).
  - ovf = (e>=158) except the case {sign=1, e=158, frac=0}.
  - shl = e-150 (3 bits) when 150<=e<=157, else 0.
  - shr = 150-e saturated to 31 when e<150, else 0.
  - Flag selecting left versus right path.
- Stage 2 (registered outputs):
  - Left path: mag = m24 << shl (exact); ine=0.
  - Right path: mag = m24 >> shr. guard = last bit shifted out. sticky = OR of the remaining shifted-out bits. For shr>=25 all of m24 contributes to guard/sticky (guard=0 when shr>=25).
  - Increment rule:
    - RNE: guard && (sticky || mag[0]).
    - RTZ: never.
    - RUP: !sign && (guard||sticky).
    - RDN: sign && (guard||sticky).
  - ine = guard||sticky. Rounding cannot overflow because mag < 2^24.
  - Result = sign ? -mag : mag. Negative zero yields 0x00000000.
  - Exactly -2^31 (0xCF000000): result 0x80000000, inv=0, ine=0.
  - nan: result 0x7FFFFFFF, inv=1, ine=0.
  - ovf (including ±inf): result 0x7FFFFFFF if sign=0, else 0x80000000; inv=1, ine=0.
  - Zero and denormals use the right path; denormals give ine=1 and a result of 0 or ±1 depending on mode.
- Outputs hold their last value while adv_i=0 or after a flush; only f2i_rdy_o qualifies them.
- Reset asserted mid-operation discards all in-flight tokens. The first result after rst_n deasserts requires a new start_i.

Test Plan:
- 0x3FC00000 (1.5): RNE -> 0x00000002, ine=1; RTZ -> 0x00000001, ine=1. 0x40200000 (2.5), RNE -> 0x00000002, ine=1.
- 0xC0200000 (-2.5): RDN -> 0xFFFFFFFD; RUP -> 0xFFFFFFFE; RTZ -> 0xFFFFFFFE; all ine=1.
- Range boundaries:
  - 0x4F000000 -> 0x7FFFFFFF, inv=1.
  - 0xCF000000 -> 0x80000000, inv=0, ine=0.
  - 0x4EFFFFFF -> 0x7FFFFF80, exact.
  - 0xFF800000 -> 0x80000000, inv=1.
- Specials:
  - 0x7FC00000 -> 0x7FFFFFFF, inv=1.
  - 0x80000000 -> 0x00000000, flags 0.
  - 0x00000001: RUP -> 0x00000001, ine=1; RNE -> 0x00000000, ine=1; RDN on 0x80000001 -> 0xFFFFFFFF.
  - 0x4B7FFFFF -> 0x00FFFFFF exact.
- Pipeline control: three back-to-back starts with adv_i=1 -> f2i_rdy_o high on cycles 2,3,4. Then:
  - adv_i=0 for 3 cycles mid-stream -> outputs and rdy frozen.
  - flush_i with adv_i=1 while 2 tokens are in flight -> rdy=0 next cycle and no stale rdy after.
- Async rst_n pulse mid-stream (off clock edge) -> rdy and outputs 0 immediately. The next start_i with adv_i=1 -> valid result 2 cycles later.

Source files
------------

// File: rtl/pu_or1k_pfpu32_f2i.sv
// Single-precision float to signed 32-bit integer converter for pfpu32.
// Stage 1 unpacks and classifies the operand; stage 2 shifts, rounds and saturates.
module pu_or1k_pfpu32_f2i (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        adv_i,
    input  logic        start_i,
    input  logic [31:0] opa_i,
    input  logic [1:0]  rmode_i,
    output logic        f2i_rdy_o,
    output logic [31:0] f2i_int_o,
    output logic        f2i_ine_o,
    output logic        f2i_inv_o
);

    localparam logic [1:0] RM_NEAREST = 2'b00;
    localparam logic [1:0] RM_ZERO    = 2'b01;
    localparam logic [1:0] RM_UP      = 2'b10;
    localparam logic [1:0] RM_DOWN    = 2'b11;

    logic        s1_valid_q,  s1_valid_d;
    logic        s1_sign_q,   s1_sign_d;
    logic [23:0] s1_m24_q,    s1_m24_d;
    logic [1:0]  s1_rmode_q,  s1_rmode_d;
    logic        s1_nan_q,    s1_nan_d;
    logic        s1_ovf_q,    s1_ovf_d;
    logic        s1_minint_q, s1_minint_d;
    logic        s1_left_q,   s1_left_d;
    logic [2:0]  s1_shl_q,    s1_shl_d;
    logic [4:0]  s1_shr_q,    s1_shr_d;

    logic        rdy_q, rdy_d;
    logic [31:0] int_q, int_d;
    logic        ine_q, ine_d;
    logic        inv_q, inv_d;

    logic [7:0]  exp_w;
    logic [22:0] frac_w;
    logic [7:0]  shl_full;
    logic [7:0]  shr_full;

    always_comb begin
        exp_w       = opa_i[30:23];
        frac_w      = opa_i[22:0];
        shl_full    = exp_w - 8'd150;
        shr_full    = 8'd150 - exp_w;
        s1_valid_d  = s1_valid_q;
        s1_sign_d   = s1_sign_q;
        s1_m24_d    = s1_m24_q;
        s1_rmode_d  = s1_rmode_q;
        s1_nan_d    = s1_nan_q;
        s1_ovf_d    = s1_ovf_q;
        s1_minint_d = s1_minint_q;
        s1_left_d   = s1_left_q;
        s1_shl_d    = s1_shl_q;
        s1_shr_d    = s1_shr_q;
        if (flush_i) begin
            s1_valid_d = 1'b0;
        end else if (adv_i) begin
            s1_valid_d = start_i;
        end
        if (adv_i) begin
            s1_sign_d   = opa_i[31];
            s1_m24_d    = {exp_w != 8'd0, frac_w};
            s1_rmode_d  = rmode_i;
            s1_nan_d    = (exp_w == 8'd255) && (frac_w != 23'd0);
            // -2^31 is the only e=158 value that fits, so it bypasses the shifter
            s1_minint_d = opa_i[31] && (exp_w == 8'd158) && (frac_w == 23'd0);
            s1_ovf_d    = (exp_w >= 8'd158) && !s1_minint_d;
            s1_left_d   = (exp_w >= 8'd150);
            s1_shl_d    = ((exp_w >= 8'd150) && (exp_w <= 8'd157)) ? shl_full[2:0] : 3'd0;
            s1_shr_d    = (exp_w < 8'd150) ? ((shr_full > 8'd31) ? 5'd31 : shr_full[4:0]) : 5'd0;
        end
    end

    logic [55:0] rnd_ext;
    logic [23:0] mag_r;
    logic        guard;
    logic        sticky;
    logic        inc;
    logic [31:0] mag;
    logic [31:0] res;
    logic        res_ine;

    always_comb begin
        // Extra 32 low bits keep every shifted-out bit visible for guard/sticky
        rnd_ext = {s1_m24_q, 32'd0} >> s1_shr_q;
        mag_r   = rnd_ext[55:32];
        guard   = rnd_ext[31];
        sticky  = |rnd_ext[30:0];
        case (s1_rmode_q)
            RM_NEAREST: inc = guard && (sticky || mag_r[0]);
            RM_ZERO:    inc = 1'b0;
            RM_UP:      inc = !s1_sign_q && (guard || sticky);
            RM_DOWN:    inc = s1_sign_q && (guard || sticky);
            default:    inc = 1'b0;
        endcase
        if (s1_left_q) begin
            mag     = {8'd0, s1_m24_q} << s1_shl_q;
            res_ine = 1'b0;
        end else begin
            mag     = {8'd0, mag_r} + {31'd0, inc};
            res_ine = guard || sticky;
        end
        res = s1_sign_q ? (32'd0 - mag) : mag;

        rdy_d = rdy_q;
        int_d = int_q;
        ine_d = ine_q;
        inv_d = inv_q;
        if (flush_i) begin
            rdy_d = 1'b0;
        end else if (adv_i) begin
            rdy_d = s1_valid_q;
        end
        if (adv_i) begin
            if (s1_nan_q) begin
                int_d = 32'h7FFF_FFFF;
                ine_d = 1'b0;
                inv_d = 1'b1;
            end else if (s1_ovf_q) begin
                int_d = s1_sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
                ine_d = 1'b0;
                inv_d = 1'b1;
            end else if (s1_minint_q) begin
                int_d = 32'h8000_0000;
                ine_d = 1'b0;
                inv_d = 1'b0;
            end else begin
                int_d = res;
                ine_d = res_ine;
                inv_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_m24_q    <= 24'd0;
            s1_rmode_q  <= 2'd0;
            s1_nan_q    <= 1'b0;
            s1_ovf_q    <= 1'b0;
            s1_minint_q <= 1'b0;
            s1_left_q   <= 1'b0;
            s1_shl_q    <= 3'd0;
            s1_shr_q    <= 5'd0;
            rdy_q       <= 1'b0;
            int_q       <= 32'd0;
            ine_q       <= 1'b0;
            inv_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_m24_q    <= s1_m24_d;
            s1_rmode_q  <= s1_rmode_d;
            s1_nan_q    <= s1_nan_d;
            s1_ovf_q    <= s1_ovf_d;
            s1_minint_q <= s1_minint_d;
            s1_left_q   <= s1_left_d;
            s1_shl_q    <= s1_shl_d;
            s1_shr_q    <= s1_shr_d;
            rdy_q       <= rdy_d;
            int_q       <= int_d;
            ine_q       <= ine_d;
            inv_q       <= inv_d;
        end
    end

    assign f2i_rdy_o = rdy_q;
    assign f2i_int_o = int_q;
    assign f2i_ine_o = ine_q;
    assign f2i_inv_o = inv_q;

endmodule

// File: tb/tb_pu_or1k_pfpu32_f2i.sv
// Scoreboard bench for the float-to-int converter: directed vectors with
// hand-computed results, plus stall, flush and async-reset pipeline scenarios.
module tb_pu_or1k_pfpu32_f2i;

    typedef struct packed {
        logic [31:0] opa;
        logic [1:0]  rm;
        logic [31:0] res;
        logic        ine;
        logic        inv;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        adv_i;
    logic        start_i;
    logic [31:0] opa_i;
    logic [1:0]  rmode_i;
    logic        f2i_rdy_o;
    logic [31:0] f2i_int_o;
    logic        f2i_ine_o;
    logic        f2i_inv_o;

    int          tests = 0;
    int          fails = 0;
    logic [33:0] expq[$];
    bit          adv_seen = 1'b0;
    vec_t        vecs[24];

    pu_or1k_pfpu32_f2i dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flush_i),
        .adv_i     (adv_i),
        .start_i   (start_i),
        .opa_i     (opa_i),
        .rmode_i   (rmode_i),
        .f2i_rdy_o (f2i_rdy_o),
        .f2i_int_o (f2i_int_o),
        .f2i_ine_o (f2i_ine_o),
        .f2i_inv_o (f2i_inv_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [33:0] actual, input logic [33:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input bit expect_result);
        opa_i   = v.opa;
        rmode_i = v.rm;
        start_i = 1'b1;
        adv_i   = 1'b1;
        flush_i = 1'b0;
        if (expect_result) expq.push_back({v.res, v.ine, v.inv});
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic idleCycles(input int n, input logic adv);
        start_i = 1'b0;
        adv_i   = adv;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // A result is new only when the pipe advanced on the preceding edge
    always @(posedge clk) adv_seen <= adv_i && !flush_i;

    always @(negedge clk) begin
        if (adv_seen && f2i_rdy_o === 1'b1) begin
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_rdy: got result %h with no pending token", f2i_int_o);
            end else begin
                checkOutput("result", {f2i_int_o, f2i_ine_o, f2i_inv_o}, expq.pop_front());
            end
        end
    end

    initial begin
        int budget;
        vecs = '{
            '{32'h3FC00000, 2'd0, 32'h00000002, 1'b1, 1'b0},
            '{32'h3FC00000, 2'd1, 32'h00000001, 1'b1, 1'b0},
            '{32'h40200000, 2'd0, 32'h00000002, 1'b1, 1'b0},
            '{32'hC0200000, 2'd3, 32'hFFFFFFFD, 1'b1, 1'b0},
            '{32'hC0200000, 2'd2, 32'hFFFFFFFE, 1'b1, 1'b0},
            '{32'hC0200000, 2'd1, 32'hFFFFFFFE, 1'b1, 1'b0},
            '{32'hC0200000, 2'd0, 32'hFFFFFFFE, 1'b1, 1'b0},
            '{32'h4F000000, 2'd0, 32'h7FFFFFFF, 1'b0, 1'b1},
            '{32'hCF000000, 2'd0, 32'h80000000, 1'b0, 1'b0},
            '{32'h4EFFFFFF, 2'd0, 32'h7FFFFF80, 1'b0, 1'b0},
            '{32'hFF800000, 2'd0, 32'h80000000, 1'b0, 1'b1},
            '{32'h7F800000, 2'd1, 32'h7FFFFFFF, 1'b0, 1'b1},
            '{32'h7FC00000, 2'd0, 32'h7FFFFFFF, 1'b0, 1'b1},
            '{32'hFFC00000, 2'd2, 32'h7FFFFFFF, 1'b0, 1'b1},
            '{32'hCF000001, 2'd0, 32'h80000000, 1'b0, 1'b1},
            '{32'h80000000, 2'd0, 32'h00000000, 1'b0, 1'b0},
            '{32'h00000001, 2'd2, 32'h00000001, 1'b1, 1'b0},
            '{32'h00000001, 2'd0, 32'h00000000, 1'b1, 1'b0},
            '{32'h80000001, 2'd3, 32'hFFFFFFFF, 1'b1, 1'b0},
            '{32'h4B7FFFFF, 2'd0, 32'h00FFFFFF, 1'b0, 1'b0},
            '{32'h3F800000, 2'd3, 32'h00000001, 1'b0, 1'b0},
            '{32'h3F000000, 2'd0, 32'h00000000, 1'b1, 1'b0},
            '{32'h3F000000, 2'd2, 32'h00000001, 1'b1, 1'b0},
            '{32'hC2F70000, 2'd1, 32'hFFFFFF85, 1'b1, 1'b0}
        };

        rst_n   = 1'b0;
        flush_i = 1'b0;
        adv_i   = 1'b0;
        start_i = 1'b0;
        opa_i   = 32'd0;
        rmode_i = 2'd0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_state", {f2i_rdy_o, f2i_int_o, f2i_ine_o}, 34'd0);
        checkOutput("reset_inv", {33'd0, f2i_inv_o}, 34'd0);

        // Directed vectors, each drained before the next
        foreach (vecs[i]) begin
            applyStimulus(vecs[i], 1'b1);
            idleCycles(3, 1'b1);
        end

        // Back-to-back: rdy on cycles 2, 3, 4
        applyStimulus(vecs[0], 1'b1);
        checkOutput("b2b_rdy_c1", {33'd0, f2i_rdy_o}, 34'd0);
        applyStimulus(vecs[3], 1'b1);
        checkOutput("b2b_rdy_c2", {33'd0, f2i_rdy_o}, 34'd1);
        applyStimulus(vecs[9], 1'b1);
        checkOutput("b2b_rdy_c3", {33'd0, f2i_rdy_o}, 34'd1);
        idleCycles(1, 1'b1);
        checkOutput("b2b_rdy_c4", {33'd0, f2i_rdy_o}, 34'd1);
        idleCycles(1, 1'b1);
        checkOutput("b2b_rdy_c5", {33'd0, f2i_rdy_o}, 34'd0);
        idleCycles(2, 1'b1);

        // Stall for three cycles with two tokens in flight
        applyStimulus(vecs[4], 1'b1);
        applyStimulus(vecs[19], 1'b1);
        for (int i = 0; i < 3; i++) begin
            idleCycles(1, 1'b0);
            checkOutput("stall_hold", {f2i_int_o, f2i_ine_o, f2i_inv_o},
                        {vecs[4].res, vecs[4].ine, vecs[4].inv});
            checkOutput("stall_rdy", {33'd0, f2i_rdy_o}, 34'd1);
        end
        idleCycles(3, 1'b1);

        // Flush with two tokens in flight: the stage-1 token is dropped
        applyStimulus(vecs[8], 1'b1);
        applyStimulus(vecs[10], 1'b0);
        flush_i = 1'b1;
        adv_i   = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        checkOutput("flush_rdy", {33'd0, f2i_rdy_o}, 34'd0);
        idleCycles(3, 1'b1);
        checkOutput("flush_no_stale", {33'd0, f2i_rdy_o}, 34'd0);

        // Async reset pulse between edges
        applyStimulus(vecs[0], 1'b0);
        applyStimulus(vecs[7], 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", {f2i_rdy_o, f2i_int_o, f2i_ine_o}, 34'd0);
        checkOutput("async_reset_inv", {33'd0, f2i_inv_o}, 34'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idleCycles(2, 1'b1);
        checkOutput("post_reset_idle", {33'd0, f2i_rdy_o}, 34'd0);
        applyStimulus(vecs[3], 1'b1);
        checkOutput("post_reset_c1", {33'd0, f2i_rdy_o}, 34'd0);
        idleCycles(1, 1'b1);
        checkOutput("post_reset_c2", {f2i_rdy_o, f2i_int_o, f2i_ine_o},
                    {1'b1, vecs[3].res, vecs[3].ine});
        idleCycles(2, 1'b1);

        budget = 0;
        while (expq.size() != 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (expq.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain: got %0d pending results, expected 0", expq.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
